// File: rtl/ifft_frame_arbiter_pkg.sv
// Shared definitions for the two-requester ifft frame arbiter.
// The codebase include normally supplies TOTAL_STAGE, REAL_WIDTH and IMGN_WIDTH.
// Guarded defaults are provided here so this slice also builds on its own.
// FRAME_LEN and the FSM state encodings are defined alongside them.
// Contents: widths, frame length, state enum, and the round-robin winner pick.
`ifndef TOTAL_STAGE
`define TOTAL_STAGE 4
`endif
`ifndef REAL_WIDTH
`define REAL_WIDTH 16
`endif
`ifndef IMGN_WIDTH
`define IMGN_WIDTH 16
`endif
`ifndef FRAME_LEN
`define FRAME_LEN (1 << `TOTAL_STAGE)
`endif
`ifndef ST_IDLE
`define ST_IDLE 1'b0
`endif
`ifndef ST_STREAM
`define ST_STREAM 1'b1
`endif

package ifft_frame_arbiter_pkg;

  localparam int STAGE_W   = `TOTAL_STAGE;
  localparam int REAL_W    = `REAL_WIDTH;
  localparam int IMAG_W    = `IMGN_WIDTH;
  localparam int FRAME_LEN = `FRAME_LEN;

  // Index of the final sample in a frame (all ones).
  localparam logic [STAGE_W-1:0] LAST_IDX = STAGE_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE   = `ST_IDLE,
    STREAM = `ST_STREAM
  } arb_state_t;

  // prio names the requester that wins a tie (the one not served last).
  function automatic logic pick_winner(input logic r0, input logic r1, input logic prio);
    if (r0 && r1) return prio;
    return r1;
  endfunction

endpackage

// File: rtl/ifft_tag_fifo.sv
// 1-bit tag FIFO holding the requester index of every frame inside the core.
// Ports:
//   iclk, rst_n  clock and asynchronous active-low reset
//   push, din    enqueue a tag (ignored when full)
//   pop          dequeue the head tag (ignored when empty)
//   full, empty  occupancy flags
//   head         oldest tag, valid while not empty
module ifft_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic iclk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // NOTE: storage needs no reset; a slot is only read after it has been written,
  // so clearing it would add reset fan-out for no functional gain.
  always_ff @(posedge iclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifft_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one ifft core between two sources.
// Ports:
//   iclk, rst_n              clock, asynchronous active-low reset
//   en                       arbitration enable (a frame in progress completes)
//   req0/req1, gnt0/gnt1     full-frame request, N-cycle grant
//   s_addr                   sample index within the granted frame
//   s_real*/s_imag*          requester samples, taken while own gnt is high
//   core_i*                  registered drive of the ifft input
//   core_o*                  ifft outputs
//   m_*                      tagged output stream (m_dest = originating requester)
//   busy, err_orphan         activity flag, sticky orphan-output error
module ifft_frame_arbiter
  import ifft_frame_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input  logic              iclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [STAGE_W-1:0] s_addr,
  input  logic [REAL_W-1:0]  s_real0,
  input  logic [IMAG_W-1:0]  s_imag0,
  input  logic [REAL_W-1:0]  s_real1,
  input  logic [IMAG_W-1:0]  s_imag1,
  output logic              core_ien,
  output logic [STAGE_W-1:0] core_iaddr,
  output logic [REAL_W-1:0]  core_iReal,
  output logic [IMAG_W-1:0]  core_iImag,
  input  logic              core_oen,
  input  logic [STAGE_W-1:0] core_oaddr,
  input  logic [REAL_W-1:0]  core_oReal,
  input  logic [IMAG_W-1:0]  core_oImag,
  output logic              m_valid,
  output logic              m_dest,
  output logic [STAGE_W-1:0] m_addr,
  output logic [REAL_W-1:0]  m_real,
  output logic [IMAG_W-1:0]  m_imag,
  output logic              m_last,
  output logic              busy,
  output logic              err_orphan
);

  arb_state_t        state, state_nxt;
  logic [STAGE_W-1:0] in_cnt;
  logic [STAGE_W-1:0] out_cnt;
  logic              prio;      // tie winner; reset 0 so req0 wins the first tie
  logic              cur_src;   // requester owning the frame being streamed
  logic              winner;
  logic              grant;
  logic              streaming;
  logic              fifo_full, fifo_empty, fifo_head;
  logic              take, pop;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = pick_winner(req0, req1, prio);
    case (state)
      IDLE: begin
        if (en && (req0 || req1) && !fifo_full) begin
          grant     = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (in_cnt == LAST_IDX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign streaming = (state == STREAM);
  assign gnt0      = streaming && !cur_src;
  assign gnt1      = streaming && cur_src;
  assign s_addr    = in_cnt;   // wraps back to 0 at frame end, so reads 0 in IDLE
  assign busy      = streaming || !fifo_empty;

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt  <= '0;
      prio    <= 1'b0;
      cur_src <= 1'b0;
    end else if (grant) begin
      in_cnt  <= '0;
      cur_src <= winner;
      prio    <= ~winner;
    end else if (streaming) begin
      in_cnt  <= in_cnt + 1'b1;
    end
  end

  // Input path: one register stage; data holds when no sample is presented.
  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      core_ien   <= 1'b0;
      core_iaddr <= '0;
      core_iReal <= '0;
      core_iImag <= '0;
    end else begin
      core_ien <= streaming;
      if (streaming) begin
        core_iaddr <= in_cnt;
        core_iReal <= cur_src ? s_real1 : s_real0;
        core_iImag <= cur_src ? s_imag1 : s_imag0;
      end
    end
  end

  // Output path: count accepted pulses; the Nth one closes the frame and
  // retires its tag. Pulses with no frame in flight are dropped and flagged.
  assign take = core_oen && !fifo_empty;
  assign pop  = take && (out_cnt == LAST_IDX);

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_dest     <= 1'b0;
      m_addr     <= '0;
      m_real     <= '0;
      m_imag     <= '0;
      out_cnt    <= '0;
      err_orphan <= 1'b0;
    end else begin
      m_valid <= take;
      m_last  <= pop;
      if (take) begin
        m_dest  <= fifo_head;
        m_addr  <= core_oaddr;
        m_real  <= core_oReal;
        m_imag  <= core_oImag;
        out_cnt <= out_cnt + 1'b1;
      end
      if (core_oen && fifo_empty) err_orphan <= 1'b1;
    end
  end

  ifft_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .iclk  (iclk),
    .rst_n (rst_n),
    .push  (grant),
    .din   (winner),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_ifft_frame_arbiter.sv
// Directed testbench for ifft_frame_arbiter (TOTAL_STAGE=4, N=16, TAG_DEPTH=4).
// The bench plays both requesters and the ifft core output side.
module tb_ifft_frame_arbiter;
  import ifft_frame_arbiter_pkg::*;

  logic              iclk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              req0, req1;
  logic              gnt0, gnt1;
  logic [STAGE_W-1:0] s_addr;
  logic [REAL_W-1:0]  s_real0, s_real1;
  logic [IMAG_W-1:0]  s_imag0, s_imag1;
  logic              core_ien;
  logic [STAGE_W-1:0] core_iaddr;
  logic [REAL_W-1:0]  core_iReal;
  logic [IMAG_W-1:0]  core_iImag;
  logic              core_oen;
  logic [STAGE_W-1:0] core_oaddr;
  logic [REAL_W-1:0]  core_oReal;
  logic [IMAG_W-1:0]  core_oImag;
  logic              m_valid, m_dest, m_last, busy, err_orphan;
  logic [STAGE_W-1:0] m_addr;
  logic [REAL_W-1:0]  m_real;
  logic [IMAG_W-1:0]  m_imag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 iclk = ~iclk;

  // Each requester presents a sample derived from the index it is asked for.
  assign s_real0 = 16'h1000 + 16'(s_addr);
  assign s_imag0 = 16'h2000 + 16'(s_addr);
  assign s_real1 = 16'h3000 + 16'(s_addr);
  assign s_imag1 = 16'h4000 + 16'(s_addr);

  ifft_frame_arbiter #(.TAG_DEPTH(4)) dut (
    .iclk       (iclk),
    .rst_n      (rst_n),
    .en         (en),
    .req0       (req0),
    .req1       (req1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .s_addr     (s_addr),
    .s_real0    (s_real0),
    .s_imag0    (s_imag0),
    .s_real1    (s_real1),
    .s_imag1    (s_imag1),
    .core_ien   (core_ien),
    .core_iaddr (core_iaddr),
    .core_iReal (core_iReal),
    .core_iImag (core_iImag),
    .core_oen   (core_oen),
    .core_oaddr (core_oaddr),
    .core_oReal (core_oReal),
    .core_oImag (core_oImag),
    .m_valid    (m_valid),
    .m_dest     (m_dest),
    .m_addr     (m_addr),
    .m_real     (m_real),
    .m_imag     (m_imag),
    .m_last     (m_last),
    .busy       (busy),
    .err_orphan (err_orphan)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0       = 1'b0;
    req1       = 1'b0;
    core_oen   = 1'b0;
    core_oaddr = '0;
    core_oReal = '0;
    core_oImag = '0;
    repeat (2) @(negedge iclk);
    rst_n = 1'b1;
  endtask

  // Returns at the first negedge where a grant is visible (bounded).
  task automatic wait_gnt();
    for (int i = 0; i < 200 && !(gnt0 || gnt1); i++) @(negedge iclk);
    check("gnt_seen", 32'(gnt0 | gnt1), 1);
  endtask

  // Drives one full core output frame and checks the tagged stream.
  task automatic out_frame(input logic dest, input logic [15:0] base);
    for (int k = 0; k < FRAME_LEN; k++) begin
      core_oen   = 1'b1;
      core_oaddr = STAGE_W'(k);
      core_oReal = base + 16'(k);
      core_oImag = ~(base + 16'(k));
      @(negedge iclk);
      check("m_valid", 32'(m_valid), 1);
      check("m_dest",  32'(m_dest), 32'(dest));
      check("m_addr",  32'(m_addr), k);
      check("m_real",  32'(m_real), 32'(base + 16'(k)));
      check("m_imag",  32'(m_imag), 32'(16'(~(base + 16'(k)))));
      check("m_last",  32'(m_last), (k == FRAME_LEN - 1) ? 1 : 0);
    end
    core_oen = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    en = 1'b1;

    // ---- reset state ----
    do_reset();
    check("reset_outputs",
          {gnt0, gnt1, s_addr, core_ien, core_iaddr, m_valid, m_dest, m_last, busy, err_orphan},
          0);
    check("reset_ireal", 32'(core_iReal), 0);
    check("reset_mreal", 32'(m_real), 0);

    // ---- single requester: 16-cycle grant, input path latency 1 ----
    req0 = 1'b1;
    wait_gnt();
    req0 = 1'b0;
    check("single_gnt1_low", 32'(gnt1), 0);
    for (int i = 0; i <= FRAME_LEN; i++) begin
      if (i < FRAME_LEN) begin
        check("single_gnt0", 32'(gnt0), 1);
        check("single_saddr", 32'(s_addr), i);
      end else begin
        check("single_gnt0_end", 32'(gnt0), 0);
      end
      if (i > 0) begin
        check("single_ien", 32'(core_ien), 1);
        check("single_iaddr", 32'(core_iaddr), i - 1);
        check("single_ireal", 32'(core_iReal), 32'h1000 + 32'(i - 1));
        check("single_iimag", 32'(core_iImag), 32'h2000 + 32'(i - 1));
      end
      @(negedge iclk);
    end
    check("single_ien_off", 32'(core_ien), 0);
    check("single_ireal_hold", 32'(core_iReal), 32'h100F);
    check("single_busy", 32'(busy), 1);
    out_frame(1'b0, 16'h0500);
    @(negedge iclk);
    check("single_mvalid_off", 32'(m_valid), 0);
    check("single_busy_done", 32'(busy), 0);

    // ---- contention + backpressure: 0,1,0,1 with period 17, then full ----
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    wait_gnt();
    check("cont_g1_gnt0", 32'(gnt0), 1);
    check("cont_g1_gnt1", 32'(gnt1), 0);
    repeat (16) @(negedge iclk);
    check("cont_idle_gap", 32'(gnt0 | gnt1), 0);
    @(negedge iclk);
    check("cont_g2_gnt1", 32'(gnt1), 1);
    repeat (17) @(negedge iclk);
    check("cont_g3_gnt0", 32'(gnt0), 1);
    repeat (17) @(negedge iclk);
    check("cont_g4_gnt1", 32'(gnt1), 1);
    repeat (16) @(negedge iclk);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (gnt0 || gnt1) seen++;
      @(negedge iclk);
    end
    check("full_no_gnt", seen, 0);
    check("full_busy", 32'(busy), 1);
    out_frame(1'b0, 16'h0600);
    check("full_no_gnt_at_pop", 32'(gnt0 | gnt1), 0);
    @(negedge iclk);
    check("regrant_after_pop", 32'(gnt0), 1);
    req0 = 1'b0;
    req1 = 1'b0;

    // ---- simultaneous push/pop with 3 frames in flight ----
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    wait_gnt();
    check("sim_g1_gnt0", 32'(gnt0), 1);
    repeat (17) @(negedge iclk);
    check("sim_g2_gnt1", 32'(gnt1), 1);
    repeat (17) @(negedge iclk);
    check("sim_g3_gnt0", 32'(gnt0), 1);
    @(negedge iclk);
    // Last output pulse lands in the IDLE cycle that issues the 4th grant.
    out_frame(1'b0, 16'h0700);
    check("sim_g4_gnt1", 32'(gnt1), 1);
    repeat (17) @(negedge iclk);
    check("sim_g5_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    req1 = 1'b0;
    out_frame(1'b1, 16'h0800);
    out_frame(1'b0, 16'h0900);
    out_frame(1'b1, 16'h0A00);
    out_frame(1'b0, 16'h0B00);
    @(negedge iclk);
    check("sim_busy_done", 32'(busy), 0);
    check("sim_no_orphan", 32'(err_orphan), 0);

    // ---- orphan output and en gating ----
    do_reset();
    en   = 1'b0;
    req0 = 1'b1;
    core_oen = 1'b1;
    @(negedge iclk);
    core_oen = 1'b0;
    check("orphan_mvalid", 32'(m_valid), 0);
    check("orphan_err", 32'(err_orphan), 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (gnt0 || gnt1) seen++;
      @(negedge iclk);
    end
    check("en_low_no_gnt", seen, 0);
    check("orphan_sticky", 32'(err_orphan), 1);
    en = 1'b1;
    do_reset();
    check("orphan_cleared", 32'(err_orphan), 0);

    // ---- reset mid-frame ----
    req0 = 1'b1;
    wait_gnt();
    req0 = 1'b0;
    repeat (7) @(negedge iclk);
    check("mid_saddr7", 32'(s_addr), 7);
    rst_n = 1'b0;
    #1;
    check("mid_async_gnt", 32'(gnt0 | gnt1), 0);
    check("mid_async_ien", 32'(core_ien), 0);
    check("mid_async_busy", 32'(busy), 0);
    req1 = 1'b1;
    @(negedge iclk);
    rst_n = 1'b1;
    wait_gnt();
    req1 = 1'b0;
    check("mid_gnt1", 32'(gnt1), 1);
    check("mid_gnt0", 32'(gnt0), 0);
    check("mid_saddr0", 32'(s_addr), 0);
    @(negedge iclk);
    check("mid_ien", 32'(core_ien), 1);
    check("mid_ireal", 32'(core_iReal), 32'h3000);
    check("mid_saddr1", 32'(s_addr), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifft_frame_arbiter.md
Name: ifft_frame_arbiter

Overview:
Frame-granular round-robin arbiter that shares one ifft core between two requesters. It grants whole frames of N = 2^`TOTAL_STAGE contiguous samples and drives the core input (ien/iaddr/iReal/iImag). It counts the core's output samples per frame and returns each output frame tagged with its originating requester. It sits between the two sample sources and the ifft instance, which is never modified.

Parameters:
TAG_DEPTH, 4, max frames in flight inside the core (tag FIFO depth, power of 2, >=2)

Ports:
iclk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  1  arbitration enable; low blocks new grants, a frame in progress completes
req0, req1  in  1 each  requester k has a full frame ready
gnt0, gnt1  out  1 each  high for N consecutive cycles; requester k must present a valid sample every gnt cycle
s_addr  out  `TOTAL_STAGE  sample index 0..N-1 within the granted frame, valid with gnt
s_real0/s_imag0, s_real1/s_imag1  in  `REAL_WIDTH/`IMGN_WIDTH  requester sample, sampled when own gnt high
core_ien  out  1  to ifft ien
core_iaddr  out  `TOTAL_STAGE  to ifft iaddr
core_iReal, core_iImag  out  `REAL_WIDTH/`IMGN_WIDTH  to ifft data
core_oen, core_oaddr, core_oReal, core_oImag  in  1/`TOTAL_STAGE/`REAL_WIDTH/`IMGN_WIDTH  from ifft outputs
m_valid  out  1  output sample valid
m_dest  out  1  requester index owning the output frame
m_addr  out  `TOTAL_STAGE  core_oaddr, registered
m_real, m_imag  out  `REAL_WIDTH/`IMGN_WIDTH  output sample
m_last  out  1  final (Nth) sample of the output frame
busy  out  1  state STREAM or tag FIFO non-empty
err_orphan  out  1  sticky: core_oen seen with tag FIFO empty

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer = 0 (req0 preferred first), counters 0, FIFO empty, err_orphan 0.
- FSM IDLE: grant if en && (req0||req1) && FIFO not full. Winner: if both, requester != last_served, otherwise the sole requester. On grant: push winner index to tag FIFO, last_served <= winner, sample counter <= 0, go STREAM.
- FSM STREAM: gnt_winner = 1, s_addr = counter. Counter increments each cycle. At counter == N-1, go IDLE. A minimum of 1 IDLE cycle separates frames, so frame period >= N+1.
- req is sampled only in IDLE; deassertion during STREAM is ignored. The requester is responsible for supplying data.
- Input path latency 1: with gnt_k and s_addr=a at cycle t, at t+1 core_ien=1, core_iaddr=a, core_iReal/iImag = s_real_k/s_imag_k. Otherwise core_ien=0; data holds its previous value.
- Output path latency 1: core_oen at t gives m_valid at t+1. m_addr/m_real/m_imag are registered copies; m_dest = FIFO head. The output counter counts core_oen pulses (independent of oaddr order). m_last = 1 on the pulse where the output count == N-1, which pops the FIFO and clears the count.
- Simultaneous push and pop in one cycle is legal; the count is unchanged. The pointers wrap mod TAG_DEPTH.
- FIFO full (TAG_DEPTH frames in flight) holds IDLE until a pop. The grant may issue in the cycle after the pop.
- core_oen with FIFO empty: m_valid=0, sample dropped, err_orphan set (cleared only by reset).
- en low in STREAM: frame finishes, then remain IDLE.
- Reset mid-frame: immediate clear. The partial frame is abandoned; the core shares rst_n, so no stale outputs are expected.

Decomposition:
- Shared include fft_inc.h already supplies `TOTAL_STAGE/`REAL_WIDTH/`IMGN_WIDTH. Add `FRAME_LEN (1<<`TOTAL_STAGE) and the IDLE/STREAM state encodings there.
- One sub-module: ifft_tag_fifo (1-bit wide, TAG_DEPTH deep, push/pop/full/empty/head, async reset).

Test Plan:
(All with `TOTAL_STAGE=4, N=16.)
- Single requester: req0=1 only -> gnt0 high 16 cycles, s_addr 0..15. core_ien high 16 cycles, one cycle later, with data matching. Core output frame -> 16 m_valid, m_dest=0, m_last on the 16th.
- Contention: req0=req1=1 held -> grants alternate 0,1,0,1 with 1 IDLE cycle between (period 17). m_dest order matches 0,1,0,1.
- Backpressure: core output stalled (no core_oen), both requesting -> exactly 4 frames granted, then no gnt. One output frame completes -> next grant in the following IDLE cycle.
- Simultaneous push/pop: m_last pop in the same cycle as a new grant with FIFO at 3 -> count stays 3, no overflow, tags correct.
- Orphan: core_oen pulsed after reset with no frame granted -> m_valid=0, err_orphan=1 and stays 1 until rst_n.
- Reset mid-frame: rst_n low at s_addr=7 -> gnt, core_ien, busy all 0 asynchronously. After release, req1 alone is granted first with s_addr from 0.
